wb_pipe: RTL and testbench

Registered, parametrised write-back stage for the RISC-V core. It accepts one retiring instruction per cycle from the memory stage over a valid/ready handshake, and selects the write-back source: ALU, aligned load data, or the U/J value (return address, LUI immediate, AUIPC target). It waits for variable-latency load data, drives the register-file write port one cycle after completion, and exposes forwarding/hazard information plus a retired-instruction counter.

---
 rtl/wb_pipe_pkg.sv | 36 +++
 rtl/wb_pipe_if.sv | 49 ++++
 rtl/wb_pipe_load_align.sv | 49 ++++
 rtl/wb_pipe.sv | 158 +++++++++++++++
 tb/tb_wb_pipe.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pipe_pkg.sv
//------------------------------------------------------------------------------
// Module   : wb_pkg
// Brief    : Shared encodings for the write-back stage (opcodes, load funct3,
//            source select, FSM states).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package wb_pkg;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [1:0] MEMTOREG_ALU     = 2'b00;
    localparam logic [1:0] MEMTOREG_LOAD    = 2'b01;
    localparam logic [1:0] MEMTOREG_UJ      = 2'b10;
    localparam logic [1:0] MEMTOREG_ALU_ALT = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_pipe_if.sv
//------------------------------------------------------------------------------
// Module   : wb_pipe_if
// Brief    : Memory-stage handshake, load return and register-file write bundle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface wb_pipe_if #(
    parameter int N = 32
);
    localparam int L = $clog2(N/8);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] alu_out;
    logic [N-1:0] return_addr;
    logic [N-1:0] imm_out;
    logic [N-1:0] pc_signed_offset;
    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic [1:0]   memtoreg;
    logic         regwrite;
    logic [4:0]   rd;
    logic [L-1:0] addr_lsb;
    logic         mem_rvalid;
    logic [N-1:0] mem_rdata;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [N-1:0] rf_wdata;
    logic         load_pending;
    logic [4:0]   load_pending_rd;

    modport master (
        output in_valid, alu_out, return_addr, imm_out, pc_signed_offset,
               opcode, funct3, memtoreg, regwrite, rd, addr_lsb,
               mem_rvalid, mem_rdata,
        input  in_ready, rf_we, rf_waddr, rf_wdata, load_pending, load_pending_rd
    );

    modport slave (
        input  in_valid, alu_out, return_addr, imm_out, pc_signed_offset,
               opcode, funct3, memtoreg, regwrite, rd, addr_lsb,
               mem_rvalid, mem_rdata,
        output in_ready, rf_we, rf_waddr, rf_wdata, load_pending, load_pending_rd
    );

endinterface

`default_nettype wire

// File: rtl/wb_pipe_load_align.sv
//------------------------------------------------------------------------------
// Module   : load_align
// Brief    : Extracts and sign/zero-extends the addressed lane of a load word.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module load_align
    import wb_pkg::*;
#(
    parameter int N = 32
) (
    input  wire logic [N-1:0]           mem_rdata,
    input  wire logic [2:0]             funct3,
    input  wire logic [$clog2(N/8)-1:0] addr_lsb,
    output logic      [N-1:0]           aligned
);
    localparam int L = $clog2(N/8);

    logic [L-1:0] w_half_lane;
    logic [L-1:0] w_word_lane;
    logic [7:0]   w_byte;
    logic [15:0]  w_half;
    logic [31:0]  w_word;

    // Halfword/word lanes drop the low address bits, so misaligned offsets round down.
    assign w_half_lane = addr_lsb & ~L'(1);
    assign w_word_lane = addr_lsb & ~L'(3);

    assign w_byte = 8'(mem_rdata >> {addr_lsb, 3'b000});
    assign w_half = 16'(mem_rdata >> {w_half_lane, 3'b000});
    assign w_word = 32'(mem_rdata >> {w_word_lane, 3'b000});

    always_comb begin
        aligned = N'($signed(w_word));
        case (funct3)
            F3_LB:   aligned = N'($signed(w_byte));
            F3_LBU:  aligned = N'(w_byte);
            F3_LH:   aligned = N'($signed(w_half));
            F3_LHU:  aligned = N'(w_half);
            F3_LWU:  aligned = N'(w_word);
            F3_LD:   aligned = mem_rdata;
            default: aligned = N'($signed(w_word));
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/wb_pipe.sv
//------------------------------------------------------------------------------
// Module   : wb_pipe
// Brief    : Registered write-back stage with variable-latency load wait,
//            source select, hazard info and retired-instruction counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_pipe
    import wb_pkg::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = 64
) (
    input  wire logic             clk,
    input  wire logic             rst,
    wb_pipe_if.slave              bus,
    output logic [CNT_W-1:0]      instret
);
    localparam int L = $clog2(N/8);

    wb_state_t    r_state;
    wb_state_t    w_state_nxt;

    logic         r_pend_regwrite;
    logic [4:0]   r_pend_rd;
    logic [2:0]   r_pend_funct3;
    logic [L-1:0] r_pend_lsb;

    logic         r_rf_we;
    logic [4:0]   r_rf_waddr;
    logic [N-1:0] r_rf_wdata;
    logic [CNT_W-1:0] r_instret;

    logic         w_is_load;
    logic         w_complete;
    logic         w_latch;
    logic         w_waiting;
    logic [2:0]   w_al_funct3;
    logic [L-1:0] w_al_lsb;
    logic [N-1:0] w_aligned;
    logic [N-1:0] w_uj;
    logic [N-1:0] w_sel;
    logic         w_regwrite;
    logic [4:0]   w_rd;

    assign w_is_load = (bus.memtoreg == MEMTOREG_LOAD);
    assign w_waiting = (r_state == ST_WAIT_MEM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_complete          = 1'b0;
        w_latch             = 1'b0;
        bus.in_ready        = 1'b0;
        bus.load_pending    = 1'b0;
        bus.load_pending_rd = 5'd0;
        case (r_state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (!w_is_load || bus.mem_rvalid) begin
                        w_complete = 1'b1;
                    end else begin
                        w_latch     = 1'b1;
                        w_state_nxt = ST_WAIT_MEM;
                    end
                end
            end
            ST_WAIT_MEM: begin
                bus.load_pending    = 1'b1;
                bus.load_pending_rd = r_pend_rd;
                if (bus.mem_rvalid) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // While waiting, the instruction fields come from the latch, not the live bus.
    assign w_al_funct3 = w_waiting ? r_pend_funct3   : bus.funct3;
    assign w_al_lsb    = w_waiting ? r_pend_lsb      : bus.addr_lsb;
    assign w_regwrite  = w_waiting ? r_pend_regwrite : bus.regwrite;
    assign w_rd        = w_waiting ? r_pend_rd       : bus.rd;

    load_align #(.N(N)) u_load_align (
        .mem_rdata (bus.mem_rdata),
        .funct3    (w_al_funct3),
        .addr_lsb  (w_al_lsb),
        .aligned   (w_aligned)
    );

    always_comb begin
        w_uj = bus.return_addr;
        case (bus.opcode)
            OP_LUI:           w_uj = bus.imm_out;
            OP_AUIPC:         w_uj = bus.pc_signed_offset;
            OP_JAL, OP_JALR:  w_uj = bus.return_addr;
            default:          w_uj = bus.return_addr;
        endcase
    end

    always_comb begin
        w_sel = bus.alu_out;
        if (w_waiting) begin
            w_sel = w_aligned;
        end else begin
            case (bus.memtoreg)
                MEMTOREG_LOAD: w_sel = w_aligned;
                MEMTOREG_UJ:   w_sel = w_uj;
                default:       w_sel = bus.alu_out;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_regwrite <= 1'b0;
            r_pend_rd       <= 5'd0;
            r_pend_funct3   <= 3'd0;
            r_pend_lsb      <= '0;
            r_rf_we         <= 1'b0;
            r_rf_waddr      <= 5'd0;
            r_rf_wdata      <= '0;
            r_instret       <= '0;
        end else begin
            if (w_latch) begin
                r_pend_regwrite <= bus.regwrite;
                r_pend_rd       <= bus.rd;
                r_pend_funct3   <= bus.funct3;
                r_pend_lsb      <= bus.addr_lsb;
            end
            r_rf_we <= w_complete && w_regwrite && (w_rd != 5'd0);
            if (w_complete) begin
                r_rf_waddr <= w_rd;
                r_rf_wdata <= w_sel;
                r_instret  <= r_instret + CNT_W'(1);
            end
        end
    end

    assign bus.rf_we    = r_rf_we;
    assign bus.rf_waddr = r_rf_waddr;
    assign bus.rf_wdata = r_rf_wdata;
    assign instret      = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_wb_pipe.sv
//------------------------------------------------------------------------------
// Module   : tb_wb_pipe
// Brief    : Self-checking bench for wb_pipe with a write scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_pipe;
    import wb_pkg::*;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] instret;
    logic [3:0]  instret_w;
    exp_t        sb_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;

    wb_pipe_if #(.N(32)) bus ();
    wb_pipe_if #(.N(32)) bus_w ();

    always #5 clk = ~clk;

    wb_pipe #(.N(32), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .bus(bus), .instret(instret)
    );

    wb_pipe #(.N(32), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .bus(bus_w), .instret(instret_w)
    );

    // Narrow-counter copy sees exactly the same instruction stream.
    assign bus_w.in_valid         = bus.in_valid;
    assign bus_w.alu_out          = bus.alu_out;
    assign bus_w.return_addr      = bus.return_addr;
    assign bus_w.imm_out          = bus.imm_out;
    assign bus_w.pc_signed_offset = bus.pc_signed_offset;
    assign bus_w.opcode           = bus.opcode;
    assign bus_w.funct3           = bus.funct3;
    assign bus_w.memtoreg         = bus.memtoreg;
    assign bus_w.regwrite         = bus.regwrite;
    assign bus_w.rd               = bus.rd;
    assign bus_w.addr_lsb         = bus.addr_lsb;
    assign bus_w.mem_rvalid       = bus.mem_rvalid;
    assign bus_w.mem_rdata        = bus.mem_rdata;

    always @(negedge clk) begin
        exp_t e;
        if (bus.rf_we === 1'b1) begin
            tests_run++;
            if (sb_q.size() == 0) begin
                tests_failed++;
                $display("FAIL wr_unexpected: got addr=%0d data=%h, required no write",
                         bus.rf_waddr, bus.rf_wdata);
            end else begin
                e = sb_q.pop_front();
                if ({bus.rf_waddr, bus.rf_wdata} !== {e.a, e.d}) begin
                    tests_failed++;
                    $display("FAIL wr_data: got addr=%0d data=%h, required addr=%0d data=%h",
                             bus.rf_waddr, bus.rf_wdata, e.a, e.d);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.in_valid         = 1'b0;
        bus.mem_rvalid       = 1'b0;
        bus.memtoreg         = MEMTOREG_ALU;
        bus.opcode           = 7'b0110011;
        bus.funct3           = 3'd0;
        bus.regwrite         = 1'b1;
        bus.rd               = 5'd0;
        bus.addr_lsb         = 2'd0;
        bus.mem_rdata        = 32'h80FF7F01;
        bus.alu_out          = 32'hA1A1A1A1;
        bus.imm_out          = 32'hB2B2B2B2;
        bus.pc_signed_offset = 32'hC3C3C3C3;
        bus.return_addr      = 32'hD4D4D4D4;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic send_load(input logic [2:0] f3, input logic [1:0] lsb,
                             input logic [4:0] rdv, input logic rv);
        bus.in_valid   = 1'b1;
        bus.memtoreg   = MEMTOREG_LOAD;
        bus.opcode     = 7'b0000011;
        bus.funct3     = f3;
        bus.addr_lsb   = lsb;
        bus.rd         = rdv;
        bus.regwrite   = 1'b1;
        bus.mem_rvalid = rv;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
        tests_run++; if (bus.rf_we !== 1'b0) begin tests_failed++; $display("FAIL reset_rf_we: got %b, required 0", bus.rf_we); end
        tests_run++; if (bus.rf_waddr !== 5'd0) begin tests_failed++; $display("FAIL reset_rf_waddr: got %0d, required 0", bus.rf_waddr); end
        tests_run++; if (bus.rf_wdata !== 32'd0) begin tests_failed++; $display("FAIL reset_rf_wdata: got %h, required 0", bus.rf_wdata); end
        tests_run++; if (bus.load_pending !== 1'b0) begin tests_failed++; $display("FAIL reset_load_pending: got %b, required 0", bus.load_pending); end
        tests_run++; if (bus.load_pending_rd !== 5'd0) begin tests_failed++; $display("FAIL reset_pending_rd: got %0d, required 0", bus.load_pending_rd); end
        tests_run++; if (instret !== 64'd0) begin tests_failed++; $display("FAIL reset_instret: got %0d, required 0", instret); end
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic exp_we;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc();
            bus.in_valid = 1'b1;
            bus.memtoreg = MEMTOREG_ALU;
            bus.regwrite = 1'b1;
            bus.rd       = 5'(i + 1);
            bus.alu_out  = 32'h10 + 32'(i);
            expect_wr(5'(i + 1), 32'h10 + 32'(i));
            @(negedge clk);
            exp_we = (i > 0);
            tests_run++; if (bus.rf_we !== exp_we) begin tests_failed++; $display("FAIL b2b_we_%0d: got %b, required %b", i, bus.rf_we, exp_we); end
        end
        cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (bus.rf_we !== 1'b1) begin tests_failed++; $display("FAIL b2b_we_last: got %b, required 1", bus.rf_we); end
        cyc();
        @(negedge clk);
        tests_run++; if (bus.rf_we !== 1'b0) begin tests_failed++; $display("FAIL b2b_we_end: got %b, required 0", bus.rf_we); end
        tests_run++; if (instret !== 64'd4) begin tests_failed++; $display("FAIL b2b_instret: got %0d, required 4", instret); end
    endtask

    task automatic test_uj_select();
        logic [6:0]  ops[5];
        logic [31:0] exps[5];
        ops  = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, 7'b0001111};
        exps = '{32'h12345000, 32'h0BAD0000, 32'h00001004, 32'h00001004, 32'h00001004};
        do_reset();
        bus.imm_out          = 32'h12345000;
        bus.pc_signed_offset = 32'h0BAD0000;
        bus.return_addr      = 32'h00001004;
        bus.alu_out          = 32'h00000055;
        for (int i = 0; i < 5; i++) begin
            cyc();
            bus.in_valid = 1'b1;
            bus.memtoreg = MEMTOREG_UJ;
            bus.opcode   = ops[i];
            bus.rd       = 5'(5 + i);
            expect_wr(5'(5 + i), exps[i]);
        end
        cyc();
        bus.memtoreg = MEMTOREG_ALU_ALT;
        bus.opcode   = OP_LUI;
        bus.rd       = 5'd10;
        expect_wr(5'd10, 32'h00000055);
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        tests_run++; if (instret !== 64'd6) begin tests_failed++; $display("FAIL uj_instret: got %0d, required 6", instret); end
    endtask

    task automatic test_load_wait();
        do_reset();
        cyc();
        bus.mem_rdata = 32'h80FF7F01;
        send_load(F3_LB, 2'd3, 5'd9, 1'b0);
        expect_wr(5'd9, 32'hFFFFFF80);
        cyc();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                cyc();
                if (k == 2) bus.mem_rvalid = 1'b1;
            end
            @(negedge clk);
            tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL wait_in_ready_%0d: got %b, required 0", k, bus.in_ready); end
            tests_run++; if (bus.load_pending !== 1'b1) begin tests_failed++; $display("FAIL wait_pending_%0d: got %b, required 1", k, bus.load_pending); end
            tests_run++; if (bus.load_pending_rd !== 5'd9) begin tests_failed++; $display("FAIL wait_pending_rd_%0d: got %0d, required 9", k, bus.load_pending_rd); end
            tests_run++; if (bus.rf_we !== 1'b0) begin tests_failed++; $display("FAIL wait_we_%0d: got %b, required 0", k, bus.rf_we); end
        end
        cyc();
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        tests_run++; if (bus.rf_we !== 1'b1) begin tests_failed++; $display("FAIL wait_done_we: got %b, required 1", bus.rf_we); end
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL wait_done_ready: got %b, required 1", bus.in_ready); end
        tests_run++; if (bus.load_pending !== 1'b0) begin tests_failed++; $display("FAIL wait_done_pending: got %b, required 0", bus.load_pending); end
        // Immediate-data loads covering each extension and lane rule.
        cyc(); send_load(F3_LBU, 2'd3, 5'd10, 1'b1); expect_wr(5'd10, 32'h00000080);
        cyc(); send_load(F3_LH,  2'd2, 5'd11, 1'b1); expect_wr(5'd11, 32'hFFFF80FF);
        cyc(); send_load(F3_LHU, 2'd1, 5'd12, 1'b1); expect_wr(5'd12, 32'h00007F01);
        cyc(); send_load(F3_LW,  2'd0, 5'd13, 1'b1); expect_wr(5'd13, 32'h80FF7F01);
        cyc(); send_load(F3_LB,  2'd1, 5'd14, 1'b1); expect_wr(5'd14, 32'h0000007F);
        cyc();
        bus.in_valid = 1'b0;
        bus.mem_rvalid = 1'b1;
        cyc();
        bus.mem_rvalid = 1'b0;
        cyc();
        @(negedge clk);
        tests_run++; if (instret !== 64'd6) begin tests_failed++; $display("FAIL load_instret: got %0d, required 6", instret); end
    endtask

    task automatic test_rd0();
        do_reset();
        cyc();
        bus.in_valid = 1'b1;
        bus.memtoreg = MEMTOREG_ALU;
        bus.regwrite = 1'b1;
        bus.rd       = 5'd0;
        bus.alu_out  = 32'h77;
        cyc();
        bus.regwrite = 1'b0;
        bus.rd       = 5'd3;
        @(negedge clk);
        tests_run++; if (bus.rf_we !== 1'b0) begin tests_failed++; $display("FAIL rd0_we: got %b, required 0", bus.rf_we); end
        cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (bus.rf_we !== 1'b0) begin tests_failed++; $display("FAIL noregwrite_we: got %b, required 0", bus.rf_we); end
        tests_run++; if (instret !== 64'd2) begin tests_failed++; $display("FAIL rd0_instret: got %0d, required 2", instret); end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        cyc();
        send_load(F3_LW, 2'd0, 5'd20, 1'b0);
        cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (bus.load_pending !== 1'b1) begin tests_failed++; $display("FAIL rstw_pending: got %b, required 1", bus.load_pending); end
        cyc();
        rst = 1'b1;
        bus.mem_rvalid = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        tests_run++; if (bus.rf_we !== 1'b0) begin tests_failed++; $display("FAIL rstw_we: got %b, required 0", bus.rf_we); end
        tests_run++; if (instret !== 64'd0) begin tests_failed++; $display("FAIL rstw_instret: got %0d, required 0", instret); end
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL rstw_ready: got %b, required 1", bus.in_ready); end
        tests_run++; if (bus.load_pending !== 1'b0) begin tests_failed++; $display("FAIL rstw_pending_after: got %b, required 0", bus.load_pending); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            cyc();
            bus.in_valid = 1'b1;
            bus.memtoreg = MEMTOREG_ALU;
            bus.regwrite = 1'b0;
            bus.rd       = 5'd1;
        end
        cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (instret_w !== 4'd1) begin tests_failed++; $display("FAIL wrap_instret4: got %0d, required 1", instret_w); end
        tests_run++; if (instret !== 64'd17) begin tests_failed++; $display("FAIL wrap_instret64: got %0d, required 17", instret); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_uj_select();
        test_load_wait();
        test_rd0();
        test_reset_in_wait();
        test_wrap();
        cyc();
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_drained: got %0d pending writes, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
